uart_rx_packet_ctrl: RTL and testbench

UART_RX_PACKET_CTRL -- requirements
Module: uart_rx_packet_ctrl

---
 rtl/uart_rx_packet_ctrl_pkg.sv | 22 ++
 rtl/uart_pkt_buf.sv | 41 ++++
 rtl/uart_rx_packet_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_packet_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_packet_ctrl_pkg.sv
// Shared definitions for the UART packet receiver: FSM encoding, error codes
// and the default start-of-packet marker.
package uart_rx_packet_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_TIMEOUT  = 2'd0;
    localparam logic [1:0] ERR_FRAMING  = 2'd1;
    localparam logic [1:0] ERR_LENGTH   = 2'd2;
    localparam logic [1:0] ERR_CHECKSUM = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam int RD_ADDR_W = 5;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload store: DEPTH x 8 memory, one write port, one registered read port.
// Reads outside the memory keep the previous read value.
module uart_pkt_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int RAW   = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_we,
    input  logic [AW-1:0]  i_wr_addr,
    input  logic [7:0]     i_wr_data,
    input  logic [RAW-1:0] i_rd_addr,
    output logic [7:0]     o_rd_data
);

    localparam logic [RAW-1:0] DEPTH_L = RAW'(DEPTH);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd_data;
    logic       w_rd_in_range;

    assign w_rd_in_range = (i_rd_addr < DEPTH_L);

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= 8'd0;
        end else if (w_rd_in_range) begin
            r_rd_data <= r_mem[i_rd_addr[AW-1:0]];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// Packet framer behind a UART receiver: SYNC, LEN, payload, additive checksum.
// A good packet is held for the consumer until acknowledged.
module uart_rx_packet_ctrl
    import uart_rx_packet_ctrl_pkg::*;
#(
    parameter int         DELAY_FRAMES   = 2812,
    parameter int         TIMEOUT_FRAMES = 28120,
    parameter int         MAX_PAYLOAD    = 16,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_data_ready,
    input  logic                 rx_comm_err,
    input  logic [RD_ADDR_W-1:0] rd_addr,
    output logic [7:0]           rd_data,
    output logic                 pkt_valid,
    output logic [4:0]           pkt_len,
    input  logic                 pkt_ack,
    output logic                 pkt_err,
    output logic [1:0]           err_code,
    output logic                 overrun,
    output logic                 busy
);

    // A zero TIMEOUT_FRAMES falls back to ten character times.
    localparam int TMO_LIMIT = (TIMEOUT_FRAMES > 0) ? TIMEOUT_FRAMES : 10 * DELAY_FRAMES;
    localparam int TMO_W     = $clog2(TMO_LIMIT);
    localparam logic [TMO_W-1:0] TMO_HIT = TMO_W'(TMO_LIMIT - 2);
    localparam int AW        = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_rdy_q;
    logic             r_cerr_q;
    logic [4:0]       r_len;
    logic [4:0]       r_idx;
    logic [7:0]       r_sum;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [4:0]       r_pkt_len;
    logic             r_pkt_err;
    logic [1:0]       r_err_code;
    logic             r_overrun;

    logic       w_byte_stb;
    logic       w_fe_edge;
    logic       w_busy;
    logic       w_err_fire;
    logic [1:0] w_err_code;
    logic       w_len_load;
    logic       w_buf_we;
    logic       w_hold_load;
    logic       w_ovr_set;
    logic       w_ack_take;

    assign w_byte_stb = rx_data_ready & ~r_rdy_q;
    assign w_fe_edge  = rx_comm_err & ~r_cerr_q;
    assign w_busy     = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CHECK);

    always_comb begin
        w_state_next = r_state;
        w_err_fire   = 1'b0;
        w_err_code   = ERR_TIMEOUT;
        w_len_load   = 1'b0;
        w_buf_we     = 1'b0;
        w_hold_load  = 1'b0;
        w_ovr_set    = 1'b0;
        w_ack_take   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_byte_stb && (rx_data == SYNC_BYTE)) begin
                    w_state_next = ST_LEN;
                end
            end
            ST_LEN, ST_PAYLOAD, ST_CHECK: begin
                // Framing error outranks a byte, which outranks the timeout.
                if (w_fe_edge) begin
                    w_err_fire   = 1'b1;
                    w_err_code   = ERR_FRAMING;
                    w_state_next = ST_IDLE;
                end else if (w_byte_stb) begin
                    if (r_state == ST_LEN) begin
                        if (rx_data > MAX_LEN) begin
                            w_err_fire   = 1'b1;
                            w_err_code   = ERR_LENGTH;
                            w_state_next = ST_IDLE;
                        end else begin
                            w_len_load   = 1'b1;
                            w_state_next = (rx_data == 8'd0) ? ST_CHECK : ST_PAYLOAD;
                        end
                    end else if (r_state == ST_PAYLOAD) begin
                        w_buf_we = 1'b1;
                        if (r_idx == r_len - 5'd1) begin
                            w_state_next = ST_CHECK;
                        end
                    end else begin
                        if (rx_data == r_sum) begin
                            w_hold_load  = 1'b1;
                            w_state_next = ST_HOLD;
                        end else begin
                            w_err_fire   = 1'b1;
                            w_err_code   = ERR_CHECKSUM;
                            w_state_next = ST_IDLE;
                        end
                    end
                end else if (r_tmo_cnt == TMO_HIT) begin
                    // Taken on the edge where the count reaches TMO_LIMIT-1.
                    w_err_fire   = 1'b1;
                    w_err_code   = ERR_TIMEOUT;
                    w_state_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                w_ovr_set = w_byte_stb;
                if (pkt_ack) begin
                    w_ack_take   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rdy_q    <= 1'b0;
            r_cerr_q   <= 1'b0;
            r_len      <= 5'd0;
            r_idx      <= 5'd0;
            r_sum      <= 8'd0;
            r_tmo_cnt  <= '0;
            r_pkt_len  <= 5'd0;
            r_pkt_err  <= 1'b0;
            r_err_code <= ERR_TIMEOUT;
            r_overrun  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_rdy_q   <= rx_data_ready;
            r_cerr_q  <= rx_comm_err;
            r_pkt_err <= w_err_fire;
            if (w_err_fire) begin
                r_err_code <= w_err_code;
            end
            if (w_byte_stb || !w_busy) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_len_load) begin
                r_len <= rx_data[4:0];
                r_sum <= rx_data;
                r_idx <= 5'd0;
            end
            if (w_buf_we) begin
                r_sum <= r_sum + rx_data;
                r_idx <= r_idx + 5'd1;
            end
            if (w_hold_load) begin
                r_pkt_len <= r_len;
            end
            if (w_ack_take) begin
                r_overrun <= 1'b0;
            end else if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    uart_pkt_buf #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW),
        .RAW   (RD_ADDR_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_buf_we),
        .i_wr_addr (r_idx[AW-1:0]),
        .i_wr_data (rx_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    assign pkt_valid = (r_state == ST_HOLD);
    assign pkt_len   = r_pkt_len;
    assign pkt_err   = r_pkt_err;
    assign err_code  = r_err_code;
    assign overrun   = r_overrun;
    assign busy      = w_busy;

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Directed and randomized checks of the UART packet receiver against a
// packet-level model (checksum = LEN + payload, modulo 256).
module tb_uart_rx_packet_ctrl;

    localparam int         T_OUT = 40;
    localparam int         MAXP  = 16;
    localparam logic [7:0] SYNC  = 8'hA5;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       rx_comm_err;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       pkt_valid;
    logic [4:0] pkt_len;
    logic       pkt_ack;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       overrun;
    logic       busy;

    int n_checks    = 0;
    int n_fail      = 0;
    int err_pulses  = 0;
    int long_pulses = 0;
    logic prev_err  = 1'b0;

    uart_rx_packet_ctrl #(
        .DELAY_FRAMES   (4),
        .TIMEOUT_FRAMES (T_OUT),
        .MAX_PAYLOAD    (MAXP),
        .SYNC_BYTE      (SYNC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .rx_comm_err   (rx_comm_err),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .pkt_valid     (pkt_valid),
        .pkt_len       (pkt_len),
        .pkt_ack       (pkt_ack),
        .pkt_err       (pkt_err),
        .err_code      (err_code),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pkt_err) begin
            err_pulses++;
            if (prev_err) long_pulses++;
        end
        prev_err = pkt_err;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap = 2);
        rx_data       = b;
        rx_data_ready = 1'b1;
        @(posedge clk); #1;
        rx_data_ready = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic send_seq(input bq_t s);
        foreach (s[i]) send(s[i]);
    endtask

    task automatic ack();
        pkt_ack = 1'b1;
        @(posedge clk); #1;
        pkt_ack = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a, input logic [7:0] exp);
        rd_addr = a;
        @(posedge clk); #1;
        check(tag, rd_data, exp);
    endtask

    function automatic logic [7:0] ref_sum(input logic [7:0] len, input bq_t pay);
        int s;
        s = len;
        foreach (pay[i]) s += pay[i];
        return 8'(s % 256);
    endfunction

    bq_t        s, pay;
    int         e0, tmo_k, kind, nn;
    bit         seen, exp_ok;
    logic [7:0] len, sum, chk, b;
    logic [1:0] exp_code;

    initial begin
        rst = 1'b1; rx_data = 8'd0; rx_data_ready = 1'b0; rx_comm_err = 1'b0;
        rd_addr = 5'd0; pkt_ack = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_pkt_len",   pkt_len,   0);
        check("rst_pkt_err",   pkt_err,   0);
        check("rst_err_code",  err_code,  0);
        check("rst_overrun",   overrun,   0);
        check("rst_busy",      busy,      0);
        check("rst_rd_data",   rd_data,   0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Checksum covers LEN too, so a trailer of 66 (payload only) is rejected.
        e0 = err_pulses;
        s = {SYNC, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        send_seq(s);
        check("chk66_err_pulse", err_pulses - e0, 1);
        check("chk66_err_code",  err_code, 3);
        check("chk66_valid",     pkt_valid, 0);

        e0 = err_pulses;
        s = {SYNC, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_seq(s);
        check("pkt3_valid",  pkt_valid, 1);
        check("pkt3_len",    pkt_len, 3);
        check("pkt3_busy",   busy, 0);
        check("pkt3_no_err", err_pulses - e0, 0);
        rd_check("pkt3_rd1", 5'd1, 8'h22);
        rd_check("pkt3_rd0", 5'd0, 8'h11);
        rd_check("pkt3_rd2", 5'd2, 8'h33);
        ack();
        check("pkt3_ack_valid", pkt_valid, 0);

        s = {SYNC, 8'h01, 8'h77, 8'h78};
        send_seq(s);
        check("pkt1_valid", pkt_valid, 1);
        check("pkt1_len",   pkt_len, 1);
        rd_check("pkt1_rd0",   5'd0, 8'h77);
        rd_check("stale_rd2",  5'd2, 8'h33);
        ack();

        e0 = err_pulses;
        s = {SYNC, 8'h01, 8'h10, 8'h12};
        send_seq(s);
        check("cksum_err_pulse", err_pulses - e0, 1);
        check("cksum_err_code",  err_code, 3);
        check("cksum_valid",     pkt_valid, 0);
        check("cksum_busy",      busy, 0);

        e0 = err_pulses;
        s = {SYNC, 8'h11};
        send_seq(s);
        check("len_err_pulse", err_pulses - e0, 1);
        check("len_err_code",  err_code, 2);
        check("len_err_busy",  busy, 0);

        len = 8'd16; pay = {};
        for (int i = 0; i < 16; i++) pay.push_back(8'(i * 7 + 3));
        s = {SYNC, len};
        foreach (pay[i]) s.push_back(pay[i]);
        s.push_back(ref_sum(len, pay));
        send_seq(s);
        check("max_valid", pkt_valid, 1);
        check("max_len",   pkt_len, 16);
        rd_check("max_rd15", 5'd15, pay[15]);
        ack();

        // SYNC held high for several cycles must count as one byte.
        rx_data = SYNC; rx_data_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1; rx_data_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("held_level_busy", busy, 1);
        send(8'h00); send(8'h00);
        check("hold0_valid", pkt_valid, 1);
        check("hold0_len",   pkt_len, 0);
        e0 = err_pulses;
        send(8'h55);
        check("ovr_set",     overrun, 1);
        check("ovr_len",     pkt_len, 0);
        check("ovr_valid",   pkt_valid, 1);
        check("ovr_no_err",  err_pulses - e0, 0);
        ack();
        check("ovr_cleared", overrun, 0);
        check("ovr_ack_valid", pkt_valid, 0);

        e0 = err_pulses;
        send(SYNC); send(8'h02);
        rx_comm_err = 1'b1;
        @(posedge clk); #1;
        check("fe_pkt_err",  pkt_err, 1);
        check("fe_err_code", err_code, 1);
        check("fe_busy",     busy, 0);
        rx_comm_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("fe_one_pulse", err_pulses - e0, 1);

        e0 = err_pulses;
        rx_comm_err = 1'b1;
        @(posedge clk); #1;
        rx_comm_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("fe_idle_ignored", err_pulses - e0, 0);

        send(SYNC);
        rx_data = 8'h03; rx_data_ready = 1'b1; rx_comm_err = 1'b1;
        @(posedge clk); #1;
        rx_data_ready = 1'b0; rx_comm_err = 1'b0;
        check("prio_code", err_code, 1);
        check("prio_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;

        e0 = err_pulses;
        send(SYNC); send(8'h02); send(8'h10, 0);
        seen = 1'b0; tmo_k = 0;
        while (!seen && tmo_k < T_OUT + 10) begin
            @(posedge clk); #1;
            tmo_k++;
            if (pkt_err) seen = 1'b1;
        end
        check("tmo_seen",     seen, 1);
        check("tmo_latency",  tmo_k, T_OUT - 1);
        check("tmo_err_code", err_code, 0);
        check("tmo_busy",     busy, 0);
        repeat (2) @(posedge clk);
        #1;

        e0 = err_pulses;
        s = {SYNC, 8'h04, 8'h01, 8'h02};
        send_seq(s);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_valid", pkt_valid, 0);
        s = {SYNC, 8'h02, 8'hAB, 8'hCD, 8'h7A};
        send_seq(s);
        check("rst_mid_no_err", err_pulses - e0, 0);
        check("rst_new_valid",  pkt_valid, 1);
        check("rst_new_len",    pkt_len, 2);
        rd_check("rst_new_rd0", 5'd0, 8'hAB);
        rd_check("rst_new_rd1", 5'd1, 8'hCD);
        ack();

        for (int p = 0; p < 24; p++) begin
            kind = $urandom_range(0, 7);
            s = {};
            nn = $urandom_range(0, 2);
            for (int i = 0; i < nn; i++) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h5A;
                s.push_back(b);
            end
            len = (kind == 0) ? 8'($urandom_range(MAXP + 1, 255)) : 8'($urandom_range(0, MAXP));
            pay = {};
            if (len <= MAXP) for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
            sum = ref_sum(len, pay);
            chk = (kind == 1) ? sum + 8'($urandom_range(1, 255)) : sum;
            s.push_back(SYNC);
            s.push_back(len);
            if (len <= MAXP) begin
                foreach (pay[i]) s.push_back(pay[i]);
                s.push_back(chk);
            end
            exp_ok   = (len <= MAXP) && (chk == sum);
            exp_code = (len > MAXP) ? 2'd2 : 2'd3;
            e0 = err_pulses;
            send_seq(s);
            check($sformatf("rnd%0d_valid", p), pkt_valid, exp_ok);
            check($sformatf("rnd%0d_errcnt", p), err_pulses - e0, exp_ok ? 0 : 1);
            if (exp_ok) begin
                check($sformatf("rnd%0d_len", p), pkt_len, len);
                foreach (pay[i]) rd_check($sformatf("rnd%0d_rd%0d", p, i), 5'(i), pay[i]);
                ack();
                check($sformatf("rnd%0d_ack", p), pkt_valid, 0);
            end else begin
                check($sformatf("rnd%0d_code", p), err_code, exp_code);
            end
        end

        check("pkt_err_single_cycle", long_pulses, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
